// File: rtl/pipeline_run_controller_pkg.sv
// Shared definitions for the pipeline run/stall/flush sequencer.
package pipeline_run_controller_pkg;

  // Debug-visible run state of the pipeline.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } run_state_e;

  // Default width of the executed-cycle counter.
  localparam int unsigned NB_CYCLE_CNT_DEFAULT = 32;

  // A state drives the pipeline forward only while running or stepping.
  function automatic logic is_active(input run_state_e st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_run_controller.sv
// Central run/stall/flush sequencer for the 5-stage pipeline: debug-controlled
// global stage enable, hazard/branch merge into PC and IF/ID controls, and a
// saturating count of enabled cycles.
module pipeline_run_controller
  import pipeline_run_controller_pkg::*;
#(
  parameter int unsigned NB_CYCLE_CNT = NB_CYCLE_CNT_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_halt,
  input  logic                    i_step,
  input  logic                    i_end_of_program,
  input  logic                    i_load_use_stall,
  input  logic                    i_branch_taken,
  output logic                    o_stage_en,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_if_id_flush,
  output logic                    o_control_mux,
  output logic                    o_running,
  output logic                    o_halted,
  output logic                    o_done,
  output logic                    o_step_done,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  run_state_e              state_q, state_d;
  logic                    step_done_q, step_done_d;
  logic [NB_CYCLE_CNT-1:0] cycle_count_q, cycle_count_d;
  logic                    active;

  // State, step-done pulse and cycle counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      step_done_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_done_q   <= step_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next-state logic for the debug run controller.
  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_halt)       state_d = ST_IDLE;
        else if (i_start) state_d = ST_RUN;
        else if (i_step)  state_d = ST_STEP;
      end
      ST_RUN: begin
        if (i_end_of_program) state_d = ST_DONE;
        else if (i_halt)      state_d = ST_IDLE;
      end
      ST_STEP: begin
        // A step always lasts one cycle; the done pulse only marks a return to IDLE.
        if (i_end_of_program) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_IDLE;
          step_done_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage enables: zero-latency merge of run state, load-use stall and branch flush.
  always_comb begin
    active        = is_active(state_q);
    o_stage_en    = active;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_control_mux = 1'b0;
    if (active) begin
      if (i_branch_taken) begin
        // The squashed ID instruction makes any pending load-use stall moot.
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b1;
        o_control_mux = 1'b1;
      end else if (i_load_use_stall) begin
        o_control_mux = 1'b1;
      end else begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
      end
    end
  end

  // Saturating count of enabled cycles; stall and flush cycles are included.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (active && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
  end

  // Status decode from the registered state.
  always_comb begin
    o_running     = (state_q == ST_RUN);
    o_halted      = (state_q == ST_IDLE);
    o_done        = (state_q == ST_DONE);
    o_step_done   = step_done_q;
    o_cycle_count = cycle_count_q;
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller: directed scenarios then
// random stimulus, compared against a flag-based behavioural model. A second
// instance with a 4-bit counter exercises saturation.
module tb_pipeline_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, halt, step, eop, stall, br;

  logic a_en, a_pcw, a_ifw, a_flush, a_cmux, a_run, a_halted, a_done, a_sd;
  logic [31:0] a_cnt;
  logic b_en, b_pcw, b_ifw, b_flush, b_cmux, b_run, b_halted, b_done, b_sd;
  logic [3:0] b_cnt;

  pipeline_run_controller #(.NB_CYCLE_CNT(32)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt), .i_step(step),
    .i_end_of_program(eop), .i_load_use_stall(stall), .i_branch_taken(br),
    .o_stage_en(a_en), .o_pc_write(a_pcw), .o_if_id_write(a_ifw),
    .o_if_id_flush(a_flush), .o_control_mux(a_cmux), .o_running(a_run),
    .o_halted(a_halted), .o_done(a_done), .o_step_done(a_sd),
    .o_cycle_count(a_cnt)
  );

  pipeline_run_controller #(.NB_CYCLE_CNT(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt), .i_step(step),
    .i_end_of_program(eop), .i_load_use_stall(stall), .i_branch_taken(br),
    .o_stage_en(b_en), .o_pc_write(b_pcw), .o_if_id_write(b_ifw),
    .o_if_id_flush(b_flush), .o_control_mux(b_cmux), .o_running(b_run),
    .o_halted(b_halted), .o_done(b_done), .o_step_done(b_sd),
    .o_cycle_count(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: independent flags rather than an encoded state.
  bit m_running, m_stepping, m_finished, m_step_done;
  longint unsigned m_enabled_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit act;
    longint unsigned cap_a, cap_b;
    act   = m_running || m_stepping;
    cap_a = (m_enabled_cycles > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_enabled_cycles;
    cap_b = (m_enabled_cycles > 15) ? 15 : m_enabled_cycles;
    chk("stage_en",   {31'd0, a_en},    {31'd0, act});
    chk("pc_write",   {31'd0, a_pcw},   {31'd0, act && (br || !stall)});
    chk("if_id_wr",   {31'd0, a_ifw},   {31'd0, act && (br || !stall)});
    chk("if_id_fl",   {31'd0, a_flush}, {31'd0, act && br});
    chk("ctrl_mux",   {31'd0, a_cmux},  {31'd0, act && (br || stall)});
    chk("running",    {31'd0, a_run},   {31'd0, m_running});
    chk("halted",     {31'd0, a_halted},{31'd0, !m_running && !m_stepping && !m_finished});
    chk("done",       {31'd0, a_done},  {31'd0, m_finished});
    chk("step_done",  {31'd0, a_sd},    {31'd0, m_step_done});
    chk("cycle_cnt",  a_cnt, cap_a[31:0]);
    chk("cnt4_sat",   {28'd0, b_cnt}, cap_b[31:0]);
    chk("b_stage_en", {31'd0, b_en},  {31'd0, act});
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance model.
  task automatic cyc(input bit r, input bit s, input bit h, input bit st,
                     input bit e, input bit ls, input bit b);
    bit nr, ns, nf;
    rst = r; start = s; halt = h; step = st; eop = e; stall = ls; br = b;
    #1;
    check_outputs();
    nr = m_running; ns = 1'b0; nf = m_finished;
    if (r) begin
      nr = 0; nf = 0; m_step_done = 0; m_enabled_cycles = 0;
    end else begin
      if (m_running || m_stepping) m_enabled_cycles++;
      m_step_done = m_stepping && !e;
      if (m_finished) begin
      end else if (m_stepping) begin
        nf = e;
      end else if (m_running) begin
        if (e) begin nf = 1; nr = 0; end
        else if (h) nr = 0;
      end else begin
        if (h) ;
        else if (s) nr = 1;
        else if (st) ns = 1;
      end
    end
    @(posedge clk);
    #1;
    m_running = nr; m_stepping = ns; m_finished = nf;
  endtask

  initial begin
    rst = 1; start = 0; halt = 0; step = 0; eop = 0; stall = 0; br = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_running = 0; m_stepping = 0; m_finished = 0; m_step_done = 0;
    m_enabled_cycles = 0;

    // 1: reset then idle
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_cnt0", a_cnt, 32'd0);

    // 2: start, run 10 cycles, halt
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("run10_cnt", a_cnt, 32'd10);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // 3: three step pulses 4 cycles apart
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    end
    chk("step3_cnt", a_cnt, 32'd3);
    // step meeting a load-use stall
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // 4: hazard merge in RUN
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0, 0);

    // 5: end-of-program beats halt; DONE is sticky until reset
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // 6: saturation of the 4-bit counter, then reset mid-STEP
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("cnt4_hold15", {28'd0, b_cnt}, 32'd15);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // step ending the program gives no step-done pulse
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Random phase
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
          ($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 3) == 0,
          ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
- Central run/stall/flush sequencer for the 5-stage RISC-V pipeline.
- Owns the global stage enable under debug-unit control: run, halt, single-step, end-of-program.
- Merges the load-use stall request from hazard detection and the taken-branch flush into the final PC, IF/ID and control-mux signals.
- Counts executed (enabled) cycles for the debug unit.

Parameters:
NB_CYCLE_CNT, 32, width of executed-cycle counter (saturating)

Ports:
i_clk  in  1  system clock; all state updates on rising edge
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  debug: enter continuous run (level, sampled each cycle)
i_halt  in  1  debug: freeze pipeline
i_step  in  1  debug: execute exactly one pipeline cycle (pulse)
i_end_of_program  in  1  halt instruction reached WB stage
i_load_use_stall  in  1  load-use stall request from hazard detection
i_branch_taken  in  1  taken branch/jump resolved; wrong-path fetch must be squashed
o_stage_en  out  1  global write enable for ID/EX, EX/MEM, MEM/WB and register file
o_pc_write  out  1  PC register write enable
o_if_id_write  out  1  IF/ID register write enable
o_if_id_flush  out  1  clear IF/ID to NOP
o_control_mux  out  1  select zero control word into ID/EX (bubble)
o_running  out  1  state == RUN
o_halted  out  1  state == IDLE
o_done  out  1  state == DONE
o_step_done  out  1  one-cycle pulse after a step cycle completes
o_cycle_count  out  NB_CYCLE_CNT  number of cycles with o_stage_en=1

Behaviour:
- States: IDLE, RUN, STEP, DONE. Reset (sync) -> IDLE, o_cycle_count=0, o_step_done=0.
- Reset values follow from IDLE: o_stage_en=0, o_pc_write=0, o_if_id_write=0, o_if_id_flush=0, o_control_mux=0, o_halted=1, o_running=0, o_done=0.
- IDLE transitions, evaluated in priority order:
  - i_halt -> stay IDLE.
  - else i_start -> RUN.
  - else i_step -> STEP.
- RUN transitions:
  - i_end_of_program -> DONE (wins over i_halt).
  - else i_halt -> IDLE.
  - i_start and i_step are ignored.
- STEP: always lasts exactly one cycle.
  - i_end_of_program -> DONE; otherwise -> IDLE.
  - o_step_done=1 on the cycle after STEP, only when returning to IDLE.
  - All debug inputs are ignored during STEP.
- DONE: terminal; only i_rst leaves it. All enables are 0.
- Stage-enable logic is combinational from registered state and same-cycle inputs (zero latency).
  - Active = state in {RUN, STEP}. o_stage_en = active.
  - When not active: all write/flush/mux outputs are 0. Hazard and branch inputs are ignored.
  - Active, no hazard: o_pc_write=1, o_if_id_write=1, o_if_id_flush=0, o_control_mux=0.
  - Active, i_load_use_stall only: o_pc_write=0, o_if_id_write=0, o_control_mux=1.
  - Active, i_branch_taken, with or without stall: branch wins. o_pc_write=1, o_if_id_write=1, o_if_id_flush=1, o_control_mux=1. The wrong-path instruction in ID is squashed, so the stall is moot.
- o_cycle_count: +1 on each clock edge where o_stage_en=1. Stall and flush cycles count; they are still enabled cycles. Saturates at all-ones (no wrap).
- A step that encounters a load-use stall still consumes exactly one enabled cycle. The bubble is inserted and PC is held; the debug unit issues further steps.
- Reset asserted mid-RUN or mid-STEP: next cycle is IDLE with all counters cleared. No o_step_done pulse.

Decomposition:
- Shared cpu package: localparam state encoding (IDLE=2'b00, RUN=2'b01, STEP=2'b10, DONE=2'b11) and NB_CYCLE_CNT default.
- Single module; no sub-module warranted. The state register, output decode and saturating counter are each under ~40 lines.

Test Plan:
1. Reset, then idle 5 cycles with no inputs -> o_halted=1, all enables 0, o_cycle_count=0.
2. i_start=1 for 1 cycle, run 10 cycles, then i_halt=1 -> o_running=1 for 10 cycles, o_stage_en=1 throughout, state IDLE on the halt edge, o_cycle_count=10.
3. From IDLE, three i_step pulses 4 cycles apart -> three single o_stage_en=1 cycles, three o_step_done pulses each 1 cycle later, o_cycle_count=3.
4. In RUN: i_load_use_stall=1 alone -> pc_write=0, if_id_write=0, control_mux=1. Then stall+branch together -> pc_write=1, if_id_flush=1, control_mux=1.
5. In RUN: i_end_of_program and i_halt asserted the same cycle -> DONE, o_done=1. Later i_start/i_step have no effect; only i_rst returns to IDLE.
6. Force o_cycle_count to all-ones with NB_CYCLE_CNT=4 and run 20 cycles -> holds at 15. Assert i_rst mid-STEP -> next cycle IDLE, count 0, no o_step_done.
